// File: rtl/uart_serial_core_if.sv
// rtl/uart_serial_core_if.sv - byte-parallel host side of the UART core
interface uart_serial_core_if;
    logic       start;
    logic [7:0] data_in;
    logic       tx_busy;
    logic       tx_done;
    logic [7:0] data_out;
    logic       data_ready;
    logic       rx_busy;
    logic       framing_err;

    modport master (
        output start,
        output data_in,
        input  tx_busy,
        input  tx_done,
        input  data_out,
        input  data_ready,
        input  rx_busy,
        input  framing_err
    );

    modport slave (
        input  start,
        input  data_in,
        output tx_busy,
        output tx_done,
        output data_out,
        output data_ready,
        output rx_busy,
        output framing_err
    );
endinterface

// File: rtl/uart_serial_core.sv
// rtl/uart_serial_core.sv - 8N1 UART: shared baud tick, transmitter, oversampling receiver
module uart_serial_core #(
    parameter int BAUD_DIV   = 10,
    parameter int OVERSAMPLE = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic                tick,
    output logic                tx,
    input  logic                rx,
    uart_serial_core_if.slave   host
);

    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] OS_HALF   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // free-running baud counter; ticks are never realigned to frames
    logic [BW-1:0] baud_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            baud_cnt <= '0;
        end else if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
        end
    end

    assign tick = (baud_cnt == BAUD_LAST);

    // ---------------- transmitter ----------------
    state_t        tx_state, tx_state_next;
    logic [TW-1:0] tx_tcnt, tx_tcnt_next;
    logic [2:0]    tx_bit, tx_bit_next;
    logic [7:0]    tx_shift, tx_shift_next;
    logic          tx_next, tx_busy_next, tx_done_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state     <= ST_IDLE;
            tx_tcnt      <= '0;
            tx_bit       <= '0;
            tx_shift     <= '0;
            tx           <= 1'b1;
            host.tx_busy <= 1'b0;
            host.tx_done <= 1'b0;
        end else begin
            tx_state     <= tx_state_next;
            tx_tcnt      <= tx_tcnt_next;
            tx_bit       <= tx_bit_next;
            tx_shift     <= tx_shift_next;
            tx           <= tx_next;
            host.tx_busy <= tx_busy_next;
            host.tx_done <= tx_done_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_tcnt_next  = tx_tcnt;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_next       = tx;
        tx_busy_next  = host.tx_busy;
        tx_done_next  = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                tx_next      = 1'b1;
                tx_busy_next = 1'b0;
                if (host.start) begin
                    tx_state_next = ST_START;
                    tx_shift_next = host.data_in;
                    tx_tcnt_next  = '0;
                    tx_next       = 1'b0;
                    tx_busy_next  = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tx_tcnt == OS_LAST) begin
                        tx_state_next = ST_DATA;
                        tx_tcnt_next  = '0;
                        tx_bit_next   = '0;
                        tx_next       = tx_shift[0];
                    end else begin
                        tx_tcnt_next = tx_tcnt + T_ONE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tx_tcnt == OS_LAST) begin
                        tx_tcnt_next = '0;
                        if (tx_bit == 3'd7) begin
                            tx_state_next = ST_STOP;
                            tx_next       = 1'b1;
                        end else begin
                            // shift register keeps the next bit at [1] while [0] is on the line
                            tx_bit_next   = tx_bit + 3'd1;
                            tx_shift_next = {1'b0, tx_shift[7:1]};
                            tx_next       = tx_shift[1];
                        end
                    end else begin
                        tx_tcnt_next = tx_tcnt + T_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tx_tcnt == OS_LAST) begin
                        tx_state_next = ST_IDLE;
                        tx_tcnt_next  = '0;
                        tx_next       = 1'b1;
                        tx_busy_next  = 1'b0;
                        tx_done_next  = 1'b1;
                    end else begin
                        tx_tcnt_next = tx_tcnt + T_ONE;
                    end
                end
            end
            default: begin
                tx_state_next = ST_IDLE;
                tx_next       = 1'b1;
                tx_busy_next  = 1'b0;
            end
        endcase
    end

    // ---------------- receiver ----------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    state_t        rx_state, rx_state_next;
    logic [TW-1:0] rx_tcnt, rx_tcnt_next;
    logic [2:0]    rx_bit, rx_bit_next;
    logic [7:0]    rx_shift, rx_shift_next;
    logic [7:0]    data_out_next;
    logic          data_ready_next, rx_busy_next, framing_err_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state         <= ST_IDLE;
            rx_tcnt          <= '0;
            rx_bit           <= '0;
            rx_shift         <= '0;
            host.data_out    <= '0;
            host.data_ready  <= 1'b0;
            host.rx_busy     <= 1'b0;
            host.framing_err <= 1'b0;
        end else begin
            rx_state         <= rx_state_next;
            rx_tcnt          <= rx_tcnt_next;
            rx_bit           <= rx_bit_next;
            rx_shift         <= rx_shift_next;
            host.data_out    <= data_out_next;
            host.data_ready  <= data_ready_next;
            host.rx_busy     <= rx_busy_next;
            host.framing_err <= framing_err_next;
        end
    end

    always_comb begin
        rx_state_next    = rx_state;
        rx_tcnt_next     = rx_tcnt;
        rx_bit_next      = rx_bit;
        rx_shift_next    = rx_shift;
        data_out_next    = host.data_out;
        data_ready_next  = host.data_ready;
        rx_busy_next     = host.rx_busy;
        framing_err_next = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (tick && !rx_sync) begin
                    rx_state_next   = ST_START;
                    rx_tcnt_next    = '0;
                    rx_busy_next    = 1'b1;
                    data_ready_next = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_tcnt == OS_HALF) begin
                        rx_tcnt_next = '0;
                        rx_bit_next  = '0;
                        if (!rx_sync) begin
                            rx_state_next = ST_DATA;
                        end else begin
                            // glitch: data_ready is deliberately left cleared
                            rx_state_next = ST_IDLE;
                            rx_busy_next  = 1'b0;
                        end
                    end else begin
                        rx_tcnt_next = rx_tcnt + T_ONE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (rx_tcnt == OS_LAST) begin
                        rx_tcnt_next  = '0;
                        rx_shift_next = {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state_next = ST_STOP;
                        end else begin
                            rx_bit_next = rx_bit + 3'd1;
                        end
                    end else begin
                        rx_tcnt_next = rx_tcnt + T_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_tcnt == OS_LAST) begin
                        rx_state_next = ST_IDLE;
                        rx_tcnt_next  = '0;
                        rx_busy_next  = 1'b0;
                        if (rx_sync) begin
                            data_out_next   = rx_shift;
                            data_ready_next = 1'b1;
                        end else begin
                            framing_err_next = 1'b1;
                        end
                    end else begin
                        rx_tcnt_next = rx_tcnt + T_ONE;
                    end
                end
            end
            default: begin
                rx_state_next = ST_IDLE;
                rx_busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_serial_core.sv
// tb/tb_uart_serial_core.sv - randomized loopback and direct-drive bench for uart_serial_core
module tb_uart_serial_core;
    localparam int BAUD_DIV   = 10;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = BAUD_DIV * OVERSAMPLE;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick, tx, rx;
    logic loop_en = 1'b1;
    logic rx_drv  = 1'b1;

    uart_serial_core_if host();

    assign rx = loop_en ? tx : rx_drv;

    uart_serial_core #(.BAUD_DIV(BAUD_DIV), .OVERSAMPLE(OVERSAMPLE)) dut (
        .clk  (clk),
        .reset(reset),
        .tick (tick),
        .tx   (tx),
        .rx   (rx),
        .host (host)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_out = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one byte in loopback and check the serial waveform and the received byte.
    task automatic send_frame(input logic [7:0] b, input int hold);
        int t0, t_done, n_done, n_fe, k;
        logic [9:0] bits;
        logic rdy_at_done;
        bits = '0; t0 = -1; t_done = -1; n_done = 0; n_fe = 0; rdy_at_done = 1'b0;
        host.data_in = b;
        host.start   = 1'b1;
        for (int t = 1; t <= 2600; t++) begin
            step();
            if (t == hold) host.start = 1'b0;
            host.data_in = 8'($urandom);
            if (t0 < 0 && tx == 1'b0) t0 = t;
            if (t0 >= 0) begin
                k = t - t0 - 70;
                if (k >= 0 && k % BIT_CLKS == 0 && k / BIT_CLKS < 10) bits[k / BIT_CLKS] = tx;
                if (t == t0 + 40) check("rdy_clr_at_start", {31'd0, host.data_ready}, 32'd0);
                if (t == t0 + 800) begin
                    check("rx_busy_mid", {31'd0, host.rx_busy}, 32'd1);
                    check("tx_busy_mid", {31'd0, host.tx_busy}, 32'd1);
                end
            end
            if (host.framing_err) n_fe++;
            if (host.tx_done) begin
                n_done++;
                if (t_done < 0) begin
                    t_done = t;
                    rdy_at_done = host.data_ready;
                end
            end
            if (t_done >= 0 && t == t_done + 3) break;
        end
        host.start = 1'b0;
        check("tx_latency", t0, 1);
        check("tx_bits", {22'd0, bits}, {22'd0, 1'b1, b, 1'b0});
        check("tx_done_count", n_done, 1);
        check("frame_len_ok",
              {31'd0, (t_done - t0 >= 10 * BIT_CLKS - BAUD_DIV + 1) && (t_done - t0 <= 10 * BIT_CLKS)}, 32'd1);
        check("rdy_at_done", {31'd0, rdy_at_done}, 32'd1);
        check("fe_none", n_fe, 0);
        check("data_out", {24'd0, host.data_out}, {24'd0, b});
        check("data_ready_end", {31'd0, host.data_ready}, 32'd1);
        check("rx_busy_end", {31'd0, host.rx_busy}, 32'd0);
        check("tx_busy_end", {31'd0, host.tx_busy}, 32'd0);
        exp_out = b;
    endtask

    // Drive a frame on rx directly, one bit cell per BIT_CLKS clocks, then idle.
    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit, output int n_fe);
        logic v;
        n_fe = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) v = 1'b0;
            else if (k == 9) v = stop_bit;
            else v = b[k-1];
            rx_drv = v;
            for (int c = 0; c < BIT_CLKS; c++) begin
                step();
                if (host.framing_err) n_fe++;
            end
        end
        rx_drv = 1'b1;
        for (int c = 0; c < 300; c++) begin
            step();
            if (host.framing_err) n_fe++;
        end
    endtask

    initial begin
        int e, n_fe, seen_busy, seen_ready;
        logic [7:0] b;

        host.start   = 1'b0;
        host.data_in = 8'h00;
        reset = 1'b0;
        step();
        step();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_tx_busy", {31'd0, host.tx_busy}, 32'd0);
        check("rst_tx_done", {31'd0, host.tx_done}, 32'd0);
        check("rst_data_out", {24'd0, host.data_out}, 32'd0);
        check("rst_data_ready", {31'd0, host.data_ready}, 32'd0);
        check("rst_rx_busy", {31'd0, host.rx_busy}, 32'd0);
        check("rst_framing_err", {31'd0, host.framing_err}, 32'd0);

        // clocks counted from the release cycle itself
        reset = 1'b1;
        e = 1;
        while (!tick && e < 50) begin
            step();
            e++;
        end
        check("first_tick_clk", e, BAUD_DIV);
        e = 0;
        do begin
            step();
            e++;
        end while (!tick && e < 50);
        check("tick_period", e, BAUD_DIV);

        loop_en = 1'b1;
        send_frame(8'hAB, 6);
        send_frame(8'h00, $urandom_range(1, 6));
        send_frame(8'hFF, $urandom_range(1, 6));
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 25)) step();
            send_frame(8'($urandom), $urandom_range(1, 6));
        end

        // framing error on a directly driven frame
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat ($urandom_range(0, BIT_CLKS - 1)) step();
        drive_rx_frame(8'h55, 1'b0, n_fe);
        check("fe_count", n_fe, 1);
        check("fe_data_ready", {31'd0, host.data_ready}, 32'd0);
        check("fe_data_out", {24'd0, host.data_out}, {24'd0, exp_out});
        check("fe_rx_busy", {31'd0, host.rx_busy}, 32'd0);

        // good directly driven frame at a random phase
        b = 8'($urandom);
        repeat ($urandom_range(0, BIT_CLKS - 1)) step();
        drive_rx_frame(b, 1'b1, n_fe);
        check("drv_fe_none", n_fe, 0);
        check("drv_data_out", {24'd0, host.data_out}, {24'd0, b});
        check("drv_data_ready", {31'd0, host.data_ready}, 32'd1);
        exp_out = b;

        // three-tick low glitch
        rx_drv = 1'b0;
        seen_busy = 0; seen_ready = 0; n_fe = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (c == 3 * BAUD_DIV - 1) rx_drv = 1'b1;
            if (host.rx_busy) seen_busy = 1;
            if (c > 40 && host.data_ready) seen_ready = 1;
            if (host.framing_err) n_fe++;
        end
        check("glitch_seen_busy", seen_busy, 1);
        check("glitch_rx_busy", {31'd0, host.rx_busy}, 32'd0);
        check("glitch_no_ready", seen_ready, 0);
        check("glitch_fe", n_fe, 0);
        check("glitch_data_out", {24'd0, host.data_out}, {24'd0, exp_out});

        // reset in the middle of a data bit
        loop_en = 1'b1;
        host.data_in = 8'($urandom);
        host.start = 1'b1;
        step();
        host.start = 1'b0;
        repeat (3 * BIT_CLKS + 50) step();
        check("pre_reset_tx_busy", {31'd0, host.tx_busy}, 32'd1);
        reset = 1'b0;
        step();
        check("mid_reset_tx", {31'd0, tx}, 32'd1);
        check("mid_reset_tx_busy", {31'd0, host.tx_busy}, 32'd0);
        check("mid_reset_data_out", {24'd0, host.data_out}, 32'd0);
        reset = 1'b1;
        step();
        send_frame(8'($urandom), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
